// File: rtl/vin_unistepper_decode.sv
// Unipolar stepper phase decoder: tracks position, direction, step period and phase errors.
// Define VIN_UNISTEPPER_DECODE_FILTER_EN to compile in the FILTER_LEN-sample glitch filter.
module vin_unistepper_decode #(
  parameter int unsigned FILTER_LEN = 8,
  parameter logic [31:0] TIMEOUT    = 32'd50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        a1,
  input  logic        a2,
  input  logic        b1,
  input  logic        b2,
  output logic [31:0] position,
  output logic [31:0] period,
  output logic        dir,
  output logic        step,
  output logic        locked,
  output logic [15:0] err_count
);
  typedef enum logic {UNLOCKED, LOCKED} state_e;

  state_e      state_q, state_d;
  logic [3:0]  s1_q, s2_q, acc_q, pat;
  logic        pat_new;
  logic [1:0]  prev_q, prev_d, ph, fwd_ph, bwd_ph;
  logic        onehot, illegal;
  logic [31:0] pos_q, pos_d, per_q, per_d, ival_q, ival_d;
  logic        dir_q, dir_d, step_q, step_d, skip_q, skip_d;
  logic [15:0] err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= {b2, b1, a2, a1};
      s2_q <= s1_q;
    end
  end

`ifdef VIN_UNISTEPPER_DECODE_FILTER_EN
  localparam logic [7:0] FLEN = 8'(FILTER_LEN);
  logic [3:0] cand_q;
  logic [7:0] fcnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q <= '0;
      fcnt_q <= '0;
    end else if (s2_q != cand_q) begin
      cand_q <= s2_q;
      fcnt_q <= 8'd1;
    end else if (fcnt_q != FLEN) begin
      fcnt_q <= fcnt_q + 8'd1;
    end
  end

  assign pat     = cand_q;
  assign pat_new = (fcnt_q == FLEN) && (cand_q != acc_q);
`else
  logic unused_filter_len;
  assign unused_filter_len = ^FILTER_LEN;
  assign pat     = s2_q;
  assign pat_new = (s2_q != acc_q);
`endif

  // Only a newly accepted pattern is decoded, so a held phase cannot re-lock after an error.
  always_ff @(posedge clk) begin
    if (rst)          acc_q <= '0;
    else if (pat_new) acc_q <= pat;
  end

  always_comb begin
    onehot  = 1'b1;
    illegal = 1'b0;
    ph      = 2'd0;
    case (pat)
      4'b0001: ph = 2'd0;
      4'b0010: ph = 2'd1;
      4'b0100: ph = 2'd2;
      4'b1000: ph = 2'd3;
      4'b0000: onehot = 1'b0;
      default: begin
        onehot  = 1'b0;
        illegal = 1'b1;
      end
    endcase
  end

  assign fwd_ph = prev_q + 2'd1;
  assign bwd_ph = prev_q - 2'd1;

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    pos_d   = pos_q;
    per_d   = per_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    err_d   = err_q;
    skip_d  = skip_q;
    ival_d  = (ival_q == '1) ? ival_q : ival_q + 32'd1;
    if (!enable) begin
      state_d = UNLOCKED;
    end else begin
      // skip_q marks that the next step has no valid start point for a period measurement
      if (ival_q >= TIMEOUT) begin
        per_d  = '0;
        skip_d = 1'b1;
      end
      if (pat_new) begin
        case (state_q)
          UNLOCKED: if (onehot) begin
            state_d = LOCKED;
            prev_d  = ph;
            skip_d  = 1'b1;
          end
          LOCKED: begin
            if (onehot && ph == fwd_ph) begin
              step_d = 1'b1;
              dir_d  = 1'b1;
              pos_d  = pos_q + 32'd1;
            end else if (onehot && ph == bwd_ph) begin
              step_d = 1'b1;
              dir_d  = 1'b0;
              pos_d  = pos_q - 32'd1;
            end else if (illegal || (onehot && ph != prev_q)) begin
              err_d   = (err_q == '1) ? err_q : err_q + 16'd1;
              state_d = UNLOCKED;
            end
          end
          default: state_d = UNLOCKED;
        endcase
        if (step_d) begin
          prev_d = ph;
          ival_d = '0;
          skip_d = 1'b0;
          if (!skip_q) per_d = (ival_q == '1) ? ival_q : ival_q + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UNLOCKED;
      prev_q  <= '0;
      pos_q   <= '0;
      per_q   <= '0;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
      err_q   <= '0;
      skip_q  <= 1'b0;
      ival_q  <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      pos_q   <= pos_d;
      per_q   <= per_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      err_q   <= err_d;
      skip_q  <= skip_d;
      ival_q  <= ival_d;
    end
  end

  assign position  = pos_q;
  assign period    = per_q;
  assign dir       = dir_q;
  assign step      = step_q;
  assign locked    = (state_q == LOCKED);
  assign err_count = err_q;
endmodule

// File: tb/tb_vin_unistepper_decode.sv
// Bench for vin_unistepper_decode: directed vector table, corner sequences, randomized model check.
module tb_vin_unistepper_decode;
  localparam int          FL  = 8;
  localparam logic [31:0] TMO = 32'd400;
`ifdef VIN_UNISTEPPER_DECODE_FILTER_EN
  localparam int LAT = 2 + FL + 1;
`else
  localparam int LAT = 3;
`endif

  logic clk = 1'b0, rst = 1'b1, enable = 1'b1;
  logic a1 = 1'b0, a2 = 1'b0, b1 = 1'b0, b2 = 1'b0;
  logic [31:0] position, period;
  logic        dir, step, locked;
  logic [15:0] err_count;
  int checks = 0, failures = 0, cyc = 0, nsteps = 0;

  vin_unistepper_decode #(.FILTER_LEN(FL), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .a1(a1), .a2(a2), .b1(b1), .b2(b2),
    .position(position), .period(period), .dir(dir), .step(step),
    .locked(locked), .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (step) nsteps <= nsteps + 1;

  typedef struct {
    bit          rst_first;
    logic [3:0]  pat;
    int          hold;
    logic [31:0] pos, per;
    bit          dr, lk;
    logic [15:0] err;
  } vec_t;
  vec_t tbl[19];

  function automatic vec_t mk(bit r, logic [3:0] p, int h, logic [31:0] po, logic [31:0] pe,
                              bit d, bit l, logic [15:0] e);
    vec_t v;
    v.rst_first = r; v.pat = p; v.hold = h; v.pos = po; v.per = pe; v.dr = d; v.lk = l; v.err = e;
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] p);
    {b2, b1, a2, a1} = p;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  // Reference model: works on pattern-change events at absolute edge numbers.
  bit          m_lock, m_skip, m_dir;
  int          m_prev, m_err, m_last;
  logic [31:0] m_pos, m_per;
  logic [3:0]  m_acc;

  task automatic m_init(input int r_edge);
    m_lock = 0; m_skip = 0; m_dir = 0; m_prev = 0; m_err = 0;
    m_last = r_edge; m_pos = 0; m_per = 0; m_acc = 4'b0000;
  endtask

  task automatic m_timeout(input int e);
    if (e > m_last + int'(TMO) + 1) begin
      m_per  = 0;
      m_skip = 1;
    end
  endtask

  task automatic m_event(input logic [3:0] pat, input int e);
    int ph, d;
    bit oh;
    if (pat == m_acc) return;
    m_acc = pat;
    m_timeout(e);
    oh = ($countones(pat) == 1);
    ph = (pat == 4'b0010) ? 1 : (pat == 4'b0100) ? 2 : (pat == 4'b1000) ? 3 : 0;
    d  = (ph - m_prev + 4) % 4;
    if (!m_lock) begin
      if (oh) begin m_lock = 1; m_prev = ph; m_skip = 1; end
    end else if (pat == 4'b0000 || (oh && d == 0)) begin
    end else if (!oh || d == 2) begin
      if (m_err < 65535) m_err++;
      m_lock = 0;
    end else begin
      m_pos  = (d == 1) ? m_pos + 1 : m_pos - 1;
      m_dir  = (d == 1);
      if (!m_skip) m_per = e - m_last;
      m_skip = 0;
      m_last = e;
      m_prev = ph;
    end
  endtask

  initial begin
    int hit, cnt, n0, p;
    logic [31:0] posat;
    logic [3:0]  rp;

    tbl[0]  = mk(0, 4'b0001, 100, 32'd0,        32'd0,   0, 1, 16'd0);
    tbl[1]  = mk(0, 4'b0010, 100, 32'd1,        32'd0,   1, 1, 16'd0);
    tbl[2]  = mk(0, 4'b0100, 100, 32'd2,        32'd100, 1, 1, 16'd0);
    tbl[3]  = mk(0, 4'b1000, 100, 32'd3,        32'd100, 1, 1, 16'd0);
    tbl[4]  = mk(0, 4'b0001, 100, 32'd4,        32'd100, 1, 1, 16'd0);
    tbl[5]  = mk(1, 4'b0100, 100, 32'd0,        32'd0,   0, 1, 16'd0);
    tbl[6]  = mk(0, 4'b0010, 100, 32'hFFFFFFFF, 32'd0,   0, 1, 16'd0);
    tbl[7]  = mk(0, 4'b0001, 100, 32'hFFFFFFFE, 32'd100, 0, 1, 16'd0);
    tbl[8]  = mk(0, 4'b1000, 100, 32'hFFFFFFFD, 32'd100, 0, 1, 16'd0);
    tbl[9]  = mk(0, 4'b0001, 100, 32'hFFFFFFFE, 32'd100, 1, 1, 16'd0);
    tbl[10] = mk(0, 4'b0100, 100, 32'hFFFFFFFE, 32'd100, 1, 0, 16'd1);
    tbl[11] = mk(0, 4'b0010, 100, 32'hFFFFFFFE, 32'd100, 1, 1, 16'd1);
    tbl[12] = mk(0, 4'b0100, 100, 32'hFFFFFFFF, 32'd100, 1, 1, 16'd1);
    tbl[13] = mk(0, 4'b0011, 100, 32'hFFFFFFFF, 32'd100, 1, 0, 16'd2);
    tbl[14] = mk(0, 4'b0000, 100, 32'hFFFFFFFF, 32'd100, 1, 0, 16'd2);
    tbl[15] = mk(0, 4'b1000, 100, 32'hFFFFFFFF, 32'd100, 1, 1, 16'd2);
    tbl[16] = mk(0, 4'b0000, 150, 32'hFFFFFFFF, 32'd0,   1, 1, 16'd2);
    tbl[17] = mk(0, 4'b0001, 100, 32'd0,        32'd0,   1, 1, 16'd2);
    tbl[18] = mk(0, 4'b0010, 100, 32'd1,        32'd100, 1, 1, 16'd2);

    do_reset();
    chk("rst_position", position, 0);
    chk("rst_period", period, 0);
    chk("rst_dir", dir, 0);
    chk("rst_step", step, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err", err_count, 0);

    for (int i = 0; i < 19; i++) begin
      if (i == 5) chk("fwd_step_count", nsteps, 4);
      if (tbl[i].rst_first) do_reset();
      drive(tbl[i].pat);
      tick(tbl[i].hold);
      chk($sformatf("vec%0d_position", i), position, tbl[i].pos);
      chk($sformatf("vec%0d_period", i), period, tbl[i].per);
      chk($sformatf("vec%0d_dir", i), dir, tbl[i].dr);
      chk($sformatf("vec%0d_locked", i), locked, tbl[i].lk);
      chk($sformatf("vec%0d_err", i), err_count, tbl[i].err);
    end

    // step latency, single-cycle pulse, position updated with the pulse
    hit = -1; cnt = 0; posat = '0;
    drive(4'b0100);
    for (int k = 1; k <= LAT + 4; k++) begin
      tick(1);
      if (step) begin
        cnt++;
        if (hit < 0) begin hit = k; posat = position; end
      end
    end
    chk("step_latency", hit, LAT);
    chk("step_pulses", cnt, 1);
    chk("pos_with_step", posat, 2);

    // reset collides with a step
    drive(4'b1000);
    tick(LAT - 1);
    rst = 1'b1;
    tick(1);
    chk("rststep_step", step, 0);
    chk("rststep_position", position, 0);
    chk("rststep_locked", locked, 0);
    rst = 1'b0;
    n0 = nsteps;
    tick(30);
    chk("relock_locked", locked, 1);
    chk("relock_position", position, 0);
    chk("relock_nostep", nsteps, n0);

    // disable forces unlock and freezes counting
    enable = 1'b0;
    tick(1);
    drive(4'b0001);
    tick(30);
    chk("dis_locked", locked, 0);
    chk("dis_position", position, 0);
    chk("dis_nostep", nsteps, n0);
    enable = 1'b1;
    tick(5);
    drive(4'b0010);
    tick(30);
    chk("en_locked", locked, 1);
    chk("en_position", position, 0);
    drive(4'b0100);
    tick(30);
    chk("en_step_position", position, 1);
    chk("en_step_dir", dir, 1);

`ifdef VIN_UNISTEPPER_DECODE_FILTER_EN
    n0 = nsteps;
    drive(4'b1000);
    tick(5);
    drive(4'b0100);
    tick(40);
    chk("glitch_nostep", nsteps, n0);
    chk("glitch_position", position, 1);
    hit = -1;
    drive(4'b1000);
    for (int k = 1; k <= LAT + 4; k++) begin
      tick(1);
      if (step && hit < 0) hit = k;
    end
    chk("filter_latency", hit, LAT);
    chk("filter_position", position, 2);
`endif

    // randomized phase stream against the reference model
    do_reset();
    m_init(cyc);
    for (int it = 0; it < 120; it++) begin
      int r, h;
      r = $urandom_range(99);
      if (r < 70) rp = 4'b0001 << $urandom_range(3);
      else if (r < 85) rp = 4'b0000;
      else begin
        rp = 4'($urandom_range(15));
        while ($countones(rp) < 2) rp = 4'($urandom_range(15));
      end
      h = $urandom_range(60, 15);
      p = cyc;
      drive(rp);
      m_event(rp, p + LAT);
      tick(h);
      m_timeout(cyc + 1);
      chk($sformatf("rnd%0d_position", it), position, m_pos);
      chk($sformatf("rnd%0d_period", it), period, m_per);
      chk($sformatf("rnd%0d_dir", it), dir, m_dir);
      chk($sformatf("rnd%0d_locked", it), locked, m_lock);
      chk($sformatf("rnd%0d_err", it), err_count, 32'(m_err));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
